// File: rtl/ucie_ctl_rx.sv
// ucie_ctl_rx
// Receive-path controller for the UCIe link controller. Flits arriving on
// the RDI receive interface are buffered in a show-ahead FIFO. They are then
// presented to the FDI consumer with a valid/ready handshake, gated by the
// link state reported on FDI status. RDI has no backpressure, so a flit that
// arrives while the buffer is full (and nothing is leaving) is dropped. That
// drop raises a sticky overflow error.
//
// Ports:
//   i_clk, i_rst            clock / synchronous active-high reset
//   i_fdi_pl_state_sts      link state status (Active / LinkReset / LinkError ...)
//   i_rdi_pl_valid/_data    RDI receive flit
//   i_fdi_lp_rx_rdy         FDI consumer ready
//   i_err_clr               clears sticky overflow error
//   o_fdi_pl_valid/_data    FDI receive flit (FIFO head, zero when not valid)
//   o_rx_overf_err          sticky overflow error
//   o_rx_fifo_level         current occupancy 0..depth
//   o_rx_state              0 IDLE, 1 ACTIVE, 2 DRAIN, 3 FLUSH
module ucie_ctl_rx #(
  parameter logic [3:0] UCIE_ACTIVE    = 4'b0001,
  parameter logic [3:0] UCIE_LINKRESET = 4'b1001,
  parameter logic [3:0] UCIE_LINKERROR = 4'b1010,
  parameter int         FIFO_D_SIZE    = 64,
  parameter int         FIFO_P_SIZE    = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [3:0]             i_fdi_pl_state_sts,
  input  logic                   i_rdi_pl_valid,
  input  logic [FIFO_D_SIZE-1:0] i_rdi_pl_data,
  input  logic                   i_fdi_lp_rx_rdy,
  input  logic                   i_err_clr,
  output logic                   o_fdi_pl_valid,
  output logic [FIFO_D_SIZE-1:0] o_fdi_pl_data,
  output logic                   o_rx_overf_err,
  output logic [FIFO_P_SIZE:0]   o_rx_fifo_level,
  output logic [1:0]             o_rx_state
);

  localparam int DEPTH = 1 << FIFO_P_SIZE;
  localparam logic [FIFO_P_SIZE:0] DEPTH_L = {1'b1, {FIFO_P_SIZE{1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [FIFO_P_SIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_P_SIZE:0]   rd_ptr_q, rd_ptr_d;
  logic                   err_q, err_d;
  logic [FIFO_D_SIZE-1:0] mem_q [DEPTH];

  logic [FIFO_P_SIZE:0] level;
  logic full, empty, rd_vld, pop, push, ovf, sts_kill;

  // Extra pointer MSB makes wr-rd the true occupancy, including full.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign rd_vld   = !empty && (state_q == ACTIVE || state_q == DRAIN);
  assign pop      = rd_vld && i_fdi_lp_rx_rdy;
  // A full FIFO still takes a flit when the head leaves in the same cycle.
  assign push     = (state_q == ACTIVE) && i_rdi_pl_valid && (!full || pop);
  assign ovf      = (state_q == ACTIVE) && i_rdi_pl_valid && full && !pop;
  assign sts_kill = (i_fdi_pl_state_sts == UCIE_LINKERROR) ||
                    (i_fdi_pl_state_sts == UCIE_LINKRESET);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + {{FIFO_P_SIZE{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_P_SIZE{1'b0}}, pop};
    // Set beats clear when both land in the same cycle.
    err_d    = ovf ? 1'b1 : (i_err_clr ? 1'b0 : err_q);

    unique case (state_q)
      IDLE: begin
        if (i_fdi_pl_state_sts == UCIE_ACTIVE) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (sts_kill)                                state_d = FLUSH;
        else if (i_fdi_pl_state_sts != UCIE_ACTIVE) state_d = DRAIN;
      end
      DRAIN: begin
        // No pushes happen here, so "last entry popped" is level==1 & pop.
        if (sts_kill)                                state_d = FLUSH;
        else if (i_fdi_pl_state_sts == UCIE_ACTIVE) state_d = ACTIVE;
        else if (empty || (pop && level == {{FIFO_P_SIZE{1'b0}}, 1'b1}))
                                                     state_d = IDLE;
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Discard contents on the edge into FLUSH so the FLUSH cycle already
    // shows level 0; a pop in the leaving cycle has still been delivered.
    if (state_d == FLUSH || state_q == FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the read side is masked until written.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_P_SIZE-1:0]] <= i_rdi_pl_data;
  end

  assign o_fdi_pl_valid  = rd_vld;
  assign o_fdi_pl_data   = rd_vld ? mem_q[rd_ptr_q[FIFO_P_SIZE-1:0]] : '0;
  assign o_rx_overf_err  = err_q;
  assign o_rx_fifo_level = level;
  assign o_rx_state      = state_q;

endmodule
